// File: rtl/rvfi_check_pkg.sv
`default_nettype none
// ============================================================================
// rvfi_check_pkg : shared types and helpers for the rvfi_*_check blocks
// Revision: 1.0
// ============================================================================
package rvfi_check_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SLEEP = 2'd2,
    FAIL  = 2'd3
  } state_t;

  localparam logic [31:0] RVFI_INSN_WFI = 32'h10500073;

  function automatic logic is_wfi(input logic [31:0] insn);
    return insn == RVFI_INSN_WFI;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rvfi_popcount.sv
`default_nettype none
// ============================================================================
// rvfi_popcount : number of set bits in an NRET-wide retire strobe vector
// Revision: 1.0
// ============================================================================
module rvfi_popcount #(
  parameter int NRET = 1,
  parameter int CW   = $clog2(NRET + 1)
) (
  input  logic [NRET-1:0] bits,
  output logic [CW-1:0]   count
);

  if (NRET < 1) begin : g_bad_nret
    $error("rvfi_popcount: NRET must be >= 1");
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < NRET; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/rvfi_liveness_check.sv
`default_nettype none
// ============================================================================
// rvfi_liveness_check : bounded-gap retirement liveness checker with WFI sleep
// Revision: 1.0
// ============================================================================
module rvfi_liveness_check
  import rvfi_check_pkg::*;
#(
  parameter int NRET      = 1,
  parameter int ILEN      = 32,
  parameter int MAX_GAP   = 16,
  parameter int MIN_RET   = 1,
  parameter int WFI_SLEEP = 1,
  parameter int CNT_W     = $clog2(MAX_GAP + 2),
  parameter int RET_W     = $clog2(MIN_RET + 1) + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 trig,
  input  logic                 check,
  input  logic [NRET-1:0]      rvfi_valid,
  input  logic [NRET-1:0]      rvfi_halt,
  input  logic [NRET-1:0]      rvfi_intr,
  input  logic [NRET*ILEN-1:0] rvfi_insn,
  output logic                 okay,
  output logic [1:0]           state,
  output logic [CNT_W-1:0]     gap_cnt,
  output logic [RET_W-1:0]     ret_cnt
);

  localparam int c_pop_w = $clog2(NRET + 1);
  localparam int c_sum_w = ((RET_W > c_pop_w) ? RET_W : c_pop_w) + 1;

  if (MAX_GAP < 1) begin : g_bad_gap
    $error("rvfi_liveness_check: MAX_GAP must be >= 1");
  end
  if (NRET < 1) begin : g_bad_nret
    $error("rvfi_liveness_check: NRET must be >= 1");
  end

  state_t             r_state;
  logic [CNT_W-1:0]   r_gap_cnt;
  logic [RET_W-1:0]   r_ret_cnt;
  logic               r_okay;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_gap_nxt;
  logic [RET_W-1:0]   w_ret_nxt;
  logic [RET_W-1:0]   w_ret_sat;
  logic [c_sum_w-1:0] w_sum;
  logic [c_pop_w-1:0] w_nvalid;
  logic [NRET-1:0]    w_wfi_vec;
  logic               w_any_valid;
  logic               w_wfi_hit;
  logic               w_sleep_hit;

  rvfi_popcount #(
    .NRET (NRET),
    .CW   (c_pop_w)
  ) u_popcount (
    .bits  (rvfi_valid),
    .count (w_nvalid)
  );

  for (genvar c = 0; c < NRET; c++) begin : g_chan
    assign w_wfi_vec[c] = rvfi_valid[c] && is_wfi(32'(rvfi_insn[c*ILEN +: ILEN]));

`ifdef FORMAL
    always_comb begin
      if (!reset && rvfi_valid[c]) begin
        assume (!rvfi_halt[c]);
        if (WFI_SLEEP == 0) assume (!is_wfi(32'(rvfi_insn[c*ILEN +: ILEN])));
`ifdef RISCV_FORMAL_WAITINSN
        assume (!is_wfi(32'(rvfi_insn[c*ILEN +: ILEN])));
`endif
      end
    end
`endif
  end

  assign w_any_valid = |rvfi_valid;
  assign w_wfi_hit   = |w_wfi_vec;
  assign w_sleep_hit = (WFI_SLEEP != 0) && w_wfi_hit;

  // Sum is computed one bit wider than either operand so the clamp never sees a wrap.
  assign w_sum     = c_sum_w'(r_ret_cnt) + c_sum_w'(w_nvalid);
  assign w_ret_sat = (w_sum >= c_sum_w'(MIN_RET)) ? RET_W'(MIN_RET) : RET_W'(w_sum);

  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap_cnt;
    w_ret_nxt   = r_ret_cnt;
    case (r_state)
      IDLE: begin
        if (trig) begin
          w_state_nxt = ARMED;
          w_gap_nxt   = '0;
          w_ret_nxt   = '0;
        end
      end
      ARMED: begin
        if (w_any_valid) begin
          w_gap_nxt = '0;
          w_ret_nxt = w_ret_sat;
          if (w_sleep_hit) w_state_nxt = SLEEP;
        end else if (r_gap_cnt >= CNT_W'(MAX_GAP)) begin
          w_state_nxt = FAIL;
        end else begin
          w_gap_nxt = r_gap_cnt + CNT_W'(1);
        end
      end
      SLEEP: begin
        w_gap_nxt = '0;
        if (w_any_valid) begin
          w_ret_nxt = w_ret_sat;
          if (!w_sleep_hit) w_state_nxt = ARMED;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_gap_cnt <= '0;
      r_ret_cnt <= '0;
      r_okay    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gap_cnt <= w_gap_nxt;
      r_ret_cnt <= w_ret_nxt;
      r_okay    <= (w_ret_nxt >= RET_W'(MIN_RET)) && (w_state_nxt != FAIL);
    end
  end

  assign okay    = r_okay;
  assign state   = r_state;
  assign gap_cnt = r_gap_cnt;
  assign ret_cnt = r_ret_cnt;

`ifdef FORMAL
  always_comb begin
    if (!reset) begin
      if (check) assert (r_okay);
      assert (r_state != FAIL);
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{check, rvfi_halt, rvfi_intr};
`endif

endmodule
`default_nettype wire
